// File: rtl/ir_queue_decoder.sv
// ir_queue_decoder: prefetch FIFO in front of an instruction register with
// registered one-hot opcode decode, HALT stall/resume, illegal-opcode flag and
// sticky overflow detection.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   IIR, data         push strobe and instruction word from fetch
//   adv               control unit consumed the current IR
//   resume            releases a HALT stall
//   full, count       FIFO status (count is 0..DEPTH)
//   overflow          sticky: push dropped because FIFO was full
//   ir_valid, ir      instruction register contents
//   operand           low field of ir
//   op_onehot         one-hot opcode decode (zero when IR empty)
//   LD..HALT          named opcode strobes (0,1,2,3,4,7)
//   illegal           IR holds opcode 5 or 6
//   halted            HALT stall active
module ir_queue_decoder #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OPC_W   = 3,
    parameter int unsigned OPC_LSB = 4,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1,
    localparam int unsigned OH_W   = 2 ** OPC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IIR,
    input  logic [DATA_W-1:0]   data,
    input  logic                adv,
    input  logic                resume,
    output logic                full,
    output logic [CNT_W-1:0]    count,
    output logic                overflow,
    output logic                ir_valid,
    output logic [DATA_W-1:0]   ir,
    output logic [OPC_LSB-1:0]  operand,
    output logic [OH_W-1:0]     op_onehot,
    output logic                LD,
    output logic                ADD,
    output logic                SUB,
    output logic                AND,
    output logic                OR,
    output logic                HALT,
    output logic                illegal,
    output logic                halted
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_d;
    logic                pop_c;
    logic                push_c;
    logic                drain_c;
    logic [DATA_W-1:0]   head_c;
    logic [OPC_W-1:0]    head_opc_c;

    // Queue/IR handshake: the IR refills from the head whenever it is empty or
    // being consumed; a full FIFO still accepts a push when it also pops.
    always_comb begin
        head_c     = mem[rd_ptr_q];
        head_opc_c = head_c[OPC_LSB +: OPC_W];
        pop_c      = (count != '0) && (!ir_valid || (adv && (state_q == S_RUN)));
        push_c     = IIR && (!full || pop_c);
        drain_c    = !pop_c && adv && (state_q == S_RUN) && (count == '0) && ir_valid;
        count_d    = count + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // HALT stall: entered when a HALT word loads, left on resume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (pop_c && (head_opc_c == OPC_W'(7))) state_d = S_HALT;
            S_HALT:  if (resume) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    assign halted = (state_q == S_HALT);

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= data;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            if (IIR && full && !pop_c) overflow <= 1'b1;
        end
    end

    // Instruction register and registered decode, updated only on load/drain.
    always_ff @(posedge clk) begin
        if (rst || drain_c) begin
            ir_valid  <= 1'b0;
            ir        <= '0;
            operand   <= '0;
            op_onehot <= '0;
            LD        <= 1'b0;
            ADD       <= 1'b0;
            SUB       <= 1'b0;
            AND       <= 1'b0;
            OR        <= 1'b0;
            HALT      <= 1'b0;
            illegal   <= 1'b0;
        end else if (pop_c) begin
            ir_valid  <= 1'b1;
            ir        <= head_c;
            operand   <= head_c[OPC_LSB-1:0];
            op_onehot <= OH_W'(1) << head_opc_c;
            LD        <= (head_opc_c == OPC_W'(0));
            ADD       <= (head_opc_c == OPC_W'(1));
            SUB       <= (head_opc_c == OPC_W'(2));
            AND       <= (head_opc_c == OPC_W'(3));
            OR        <= (head_opc_c == OPC_W'(4));
            HALT      <= (head_opc_c == OPC_W'(7));
            illegal   <= (head_opc_c == OPC_W'(5)) || (head_opc_c == OPC_W'(6));
        end
    end

endmodule

// File: tb/tb_ir_queue_decoder.sv
// Bench for ir_queue_decoder: a queue scoreboard models the FIFO and IR, a
// table of vectors covers the basic decode stream, and hand sequences cover
// HALT/resume, overflow, full push+pop, illegal opcodes and mid-run reset.
module tb_ir_queue_decoder;

    logic        clk;
    logic        rst;
    logic        IIR;
    logic [7:0]  data;
    logic        adv;
    logic        resume;
    logic        full;
    logic [2:0]  count;
    logic        overflow;
    logic        ir_valid;
    logic [7:0]  ir;
    logic [3:0]  operand;
    logic [7:0]  op_onehot;
    logic        LD, ADD, SUB, AND, OR, HALT;
    logic        illegal;
    logic        halted;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [7:0] sb[$];
    bit         m_valid;
    bit         m_halted;
    bit         m_ovf;
    logic [7:0] m_ir;

    ir_queue_decoder dut (
        .clk(clk), .rst(rst), .IIR(IIR), .data(data), .adv(adv), .resume(resume),
        .full(full), .count(count), .overflow(overflow), .ir_valid(ir_valid),
        .ir(ir), .operand(operand), .op_onehot(op_onehot),
        .LD(LD), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .HALT(HALT),
        .illegal(illegal), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Compare every output against the reference state.
    task automatic check_all();
        logic [7:0] eoh;
        logic [2:0] opc;
        opc = m_ir[6:4];
        eoh = m_valid ? (8'b1 << opc) : 8'h00;
        chk("ir_valid",  32'(ir_valid),  32'(m_valid));
        chk("ir",        32'(ir),        32'(m_ir));
        chk("operand",   32'(operand),   32'(m_ir[3:0]));
        chk("op_onehot", 32'(op_onehot), 32'(eoh));
        chk("named",     32'({LD, ADD, SUB, AND, OR, HALT}),
                         32'({eoh[0], eoh[1], eoh[2], eoh[3], eoh[4], eoh[7]}));
        chk("illegal",   32'(illegal),   32'(eoh[5] | eoh[6]));
        chk("halted",    32'(halted),    32'(m_halted));
        chk("count",     32'(count),     32'(sb.size()));
        chk("full",      32'(full),      32'(sb.size() == 4));
        chk("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    // Drive one cycle, advance the reference at the edge, compare after it.
    task automatic step(input logic i_rst, input logic i_iir, input logic [7:0] d,
                        input logic i_adv, input logic i_res);
        int n;
        bit pop, fl, load;
        logic [7:0] w;
        rst = i_rst; IIR = i_iir; data = d; adv = i_adv; resume = i_res;
        @(posedge clk);
        load = 1'b0;
        w    = 8'h00;
        if (i_rst) begin
            sb.delete();
            m_valid = 0; m_halted = 0; m_ovf = 0; m_ir = 8'h00;
        end else begin
            n   = sb.size();
            pop = (n > 0) && (!m_valid || (i_adv && !m_halted));
            fl  = (n == 4);
            if (i_iir && fl && !pop) m_ovf = 1;
            if (pop) begin
                w = sb.pop_front();
                load = 1'b1;
                m_ir = w;
                m_valid = 1;
                if (w[6:4] == 3'd7) m_halted = 1;
            end else if (i_adv && !m_halted && n == 0) begin
                m_valid = 0;
                m_ir = 8'h00;
            end else if (m_halted && i_res) begin
                m_halted = 0;
            end
            if (i_iir && (!fl || pop)) sb.push_back(d);
        end
        #1;
        if (load) chk("ir_load", 32'(ir), 32'(w));
        check_all();
    endtask

    typedef struct {
        logic       iir;
        logic [7:0] d;
        logic       adv;
        logic       valid;
        logic [7:0] ir;
        logic [5:0] named;   // {LD, ADD, SUB, AND, OR, HALT}
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 8'h08, 1'b1, 1'b0, 8'h00, 6'b000000, 3'd1};
        tbl[1] = '{1'b1, 8'h19, 1'b1, 1'b1, 8'h08, 6'b100000, 3'd1};
        tbl[2] = '{1'b1, 8'h2A, 1'b1, 1'b1, 8'h19, 6'b010000, 3'd1};
        tbl[3] = '{1'b1, 8'h3B, 1'b1, 1'b1, 8'h2A, 6'b001000, 3'd1};
        tbl[4] = '{1'b1, 8'h4C, 1'b1, 1'b1, 8'h3B, 6'b000100, 3'd1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h4C, 6'b000010, 3'd0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 6'b000000, 3'd0};

        m_valid = 0; m_halted = 0; m_ovf = 0; m_ir = 8'h00;
        rst = 1'b1; IIR = 1'b0; data = 8'h00; adv = 1'b0; resume = 1'b0;

        // Reset state
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(ir_valid), 32'd0);

        // Decode stream from the table
        for (int i = 0; i < 7; i++) begin
            step(0, tbl[i].iir, tbl[i].d, tbl[i].adv, 0);
            chk($sformatf("tbl%0d_valid", i), 32'(ir_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_ir", i), 32'(ir), 32'(tbl[i].ir));
            chk($sformatf("tbl%0d_named", i), 32'({LD, ADD, SUB, AND, OR, HALT}), 32'(tbl[i].named));
            chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_opnd", i), 32'(operand), 32'(tbl[i].ir[3:0]));
        end

        // HALT stalls despite adv; resume with adv does not advance
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'h7E, 1, 0);
        step(0, 1, 8'h08, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0);
        chk("halt_ir", 32'(ir), 32'h7E);
        chk("halt_flag", 32'({HALT, halted}), 32'b11);
        chk("halt_count", 32'(count), 32'd1);
        step(0, 0, 8'h00, 1, 1);
        chk("resume_clear", 32'(halted), 32'd0);
        chk("resume_hold_ir", 32'(ir), 32'h7E);
        step(0, 0, 8'h00, 1, 0);
        chk("after_resume_ld", 32'({ir, LD}), 32'({8'h08, 1'b1}));

        // Fill, overflow drop, drain in order
        step(1, 0, 8'h00, 0, 0);
        for (int k = 1; k <= 5; k++) step(0, 1, 8'(8'h20 + k), 0, 0);
        chk("fill_full", 32'({full, count}), 32'({1'b1, 3'd4}));
        chk("fill_no_ovf", 32'(overflow), 32'd0);
        step(0, 1, 8'h26, 0, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        for (int k = 0; k < 6; k++) step(0, 0, 8'h00, 1, 0);
        chk("drain_empty", 32'({ir_valid, count}), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop together while full
        step(1, 0, 8'h00, 0, 0);
        for (int k = 1; k <= 5; k++) step(0, 1, 8'(8'h40 + k), 0, 0);
        step(0, 1, 8'h0F, 1, 0);
        chk("fullpp_count", 32'(count), 32'd4);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        chk("fullpp_ir", 32'(ir), 32'h42);

        // Illegal opcodes
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'h5D, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("ill5_oh", 32'(op_onehot), 32'b0010_0000);
        chk("ill5_flags", 32'({illegal, LD, ADD, SUB, AND, OR, HALT, halted}), 32'b1000_0000);
        step(0, 1, 8'h6F, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("ill6_oh", 32'(op_onehot), 32'b0100_0000);
        chk("ill6_flag", 32'(illegal), 32'd1);

        // Reset while halted with queued words
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'h7E, 0, 0);
        step(0, 1, 8'h11, 0, 0);
        step(0, 1, 8'h12, 0, 0);
        step(0, 1, 8'h13, 0, 0);
        chk("pre_rst", 32'({halted, count}), 32'({1'b1, 3'd3}));
        step(1, 1, 8'h19, 1, 1);
        chk("mid_rst", 32'({ir_valid, ir, count, halted, overflow, op_onehot}), 32'd0);
        step(0, 1, 8'h19, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("post_rst_add", 32'({ADD, ir}), 32'({1'b1, 8'h19}));

        // Random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_queue_decoder.md
Name: ir_queue_decoder

Overview:
- Parametrised instruction register with a small prefetch queue in front of it.
- Instruction words pushed by fetch (IIR strobe) are buffered in a DEPTH-entry FIFO.
- The head word moves into the instruction register (IR), which drives registered one-hot decode outputs to the control unit.
- Adds queueing, an advance handshake, a HALT stall with resume, illegal-opcode flagging and overflow detection.

Parameters:
- DATA_W, 8, instruction word width.
- OPC_W, 3, opcode field width.
- OPC_LSB, 4, bit position of opcode LSB; opcode = data[OPC_LSB+OPC_W-1:OPC_LSB], operand = data[OPC_LSB-1:0].
- DEPTH, 4, FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- IIR  in  1  push strobe; data captured into FIFO on this edge
- data  in  DATA_W  instruction word
- adv  in  1  control unit has consumed the current IR; advance
- resume  in  1  clears HALT stall
- full  out  1  FIFO full
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: push attempted while full and not popping
- ir_valid  out  1  IR holds a valid instruction
- ir  out  DATA_W  current instruction word
- operand  out  OPC_LSB  operand field of ir
- op_onehot  out  2**OPC_W  one-hot decode of ir opcode, all zero when !ir_valid
- LD, ADD, SUB, AND, OR, HALT  out  1 each  opcodes 0,1,2,3,4,7
- illegal  out  1  ir_valid and opcode 5 or 6
- halted  out  1  stall active

Behaviour:
- Reset: all outputs 0, including count, overflow, halted and ir_valid. FIFO pointers cleared. Reset overrides every other input in the same cycle.
- Push: at an edge with IIR=1 and (!full or pop this edge), data is written at the tail and count increments.
- Overflow: IIR=1 with full=1 and no pop drops the word and sets overflow=1 until rst.
- Pop/IR load: pop = (count>0) and (!ir_valid or (adv and !halted)). On pop, IR <= FIFO head, ir_valid <= 1, and all decode outputs are registered from the loaded word. Decode outputs change only on IR load/clear, never combinationally from data.
- Latency:
  - Push into empty FIFO with empty IR at edge N: ir_valid=1 after edge N+1.
  - No FIFO bypass.
- Empty drain: adv=1, !halted, count=0: ir_valid <= 0, ir and all decode outputs <= 0.
- Simultaneous push and pop: count unchanged, and both are permitted when full.
- HALT:
  - When the IR loads opcode 7, halted <= 1 on the same edge.
  - While halted, adv is ignored, IR and outputs hold, and pushes are still accepted.
  - resume=1 while halted: halted <= 0 at that edge. adv in the same cycle is still ignored, so the HALT is consumed only by a later adv.
  - resume while not halted has no effect.
- Illegal opcodes 5/6 load normally. illegal=1 and op_onehot has bit 5/6 set; the named outputs are all 0. No stall.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; full = (count==DEPTH).
- rst mid-operation discards FIFO contents and IR, and clears halted and overflow.

Test Plan:
- Reset then push 0x08, 0x19, 0x2A, 0x3B, 0x4C on consecutive edges, with adv=1 each cycle after ir_valid → LD, ADD, SUB, AND, OR each asserted for one cycle in order. operand = 8, 9, A, B, C. ir_valid drops after the last word.
- Push 0x7E then 0x08, with adv held 1 → HALT=1, halted=1 and IR held at 0x7E for 5+ cycles, count=1. Pulse resume → next adv loads 0x08 (LD=1).
- DEPTH=4, adv=0: push 6 words → IR takes the 1st, FIFO holds 4 (full=1, count=4). The 6th push sets overflow=1 and is dropped. Subsequent drain yields exactly words 1–5.
- Full FIFO with valid IR: IIR=1 and adv=1 on the same edge → word accepted, count stays 4, overflow stays 0.
- Push 0x5D → illegal=1, op_onehot=8'b0010_0000, named outputs all 0. Push 0x6F → op_onehot=8'b0100_0000, illegal=1.
- Assert rst while halted with count=3 → next cycle all outputs 0. A push after reset decodes normally.
